// File: rtl/xbar_pkg.sv
// Shared widths and types for the crossbar: select/ID width helpers and the
// entry stored in each per-slave outstanding-ID FIFO.
package xbar_pkg;

  localparam int unsigned MAX_ID_W = 8;

  typedef struct packed {
    logic                we;
    logic [MAX_ID_W-1:0] id;
  } id_entry_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter with a sticky lock: a presented-but-unaccepted winner is
// held until the slave accepts it, then the pointer moves past the winner.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          lock_hold_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] winner_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o      = '0;
    winner_o   = '0;
    found      = 1'b0;
    idx        = '0;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;

    if (lock_q && req_i[lock_idx_q]) begin
      winner_o = lock_idx_q;
      found    = 1'b1;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        idx = IW'((int'(ptr_q) + i) % int'(N));
        if (!found && req_i[idx]) begin
          found    = 1'b1;
          winner_o = idx;
        end
      end
    end
    if (found) gnt_o[winner_o] = 1'b1;

    // A lock whose master dropped its request is stale.
    if (lock_q && !req_i[lock_idx_q]) lock_d = 1'b0;

    if (advance_i && found) begin
      ptr_d  = (int'(winner_o) == int'(N) - 1) ? '0 : winner_o + 1'b1;
      lock_d = 1'b0;
    end else if (lock_hold_i && found) begin
      lock_d     = 1'b1;
      lock_idx_d = winner_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/xbar_interconnect.sv
// M x S crossbar: per-slave round-robin arbitration with lock under back-pressure,
// in-order response routing via per-slave ID FIFOs, and local decode-error replies.
module xbar_interconnect
  import xbar_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SEL_LSB     = 14,
  parameter int unsigned RSP_DEPTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_MASTERS-1:0]                 i_master_req,
  input  logic [NUM_MASTERS-1:0]                 i_master_we,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_master_addr,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_master_wdata,
  output logic [NUM_MASTERS-1:0]                 o_master_gnt,
  output logic [NUM_MASTERS-1:0]                 o_master_rvalid,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] o_master_rdata,
  output logic [NUM_MASTERS-1:0]                 o_master_err,
  output logic [NUM_SLAVES-1:0]                  o_slave_req,
  output logic [NUM_SLAVES-1:0]                  o_slave_we,
  output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  o_slave_addr,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  o_slave_wdata,
  input  logic [NUM_SLAVES-1:0]                  i_slave_gnt,
  input  logic [NUM_SLAVES-1:0]                  i_slave_rvalid,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  i_slave_rdata
);

  localparam int unsigned SEL_W = sel_width(NUM_SLAVES);
  localparam int unsigned IW    = id_width(NUM_MASTERS);
  localparam int unsigned PW    = $clog2(RSP_DEPTH);

  // Handshake: a transfer happens in the cycle where req & gnt are both high;
  // masters hold req/we/addr/wdata stable until then and stay busy until rvalid.
  logic [NUM_MASTERS-1:0] busy_q, busy_d, errp_q, dec_err, dec_gnt;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] cand, arb_gnt;
  logic [NUM_SLAVES-1:0][IW-1:0] arb_win;
  logic [NUM_SLAVES-1:0] slv_req, accept, lock_hold, pop, full;
  id_entry_t             push_ent [NUM_SLAVES];
  id_entry_t             fifo_q   [NUM_SLAVES][RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q [NUM_SLAVES];
  logic [PW-1:0]         rd_ptr_q [NUM_SLAVES];
  logic [PW:0]           cnt_q    [NUM_SLAVES];
  logic                  recent_rst_q;
  int unsigned           sel;
  id_entry_t             head;

  always_comb begin
    cand    = '0;
    dec_err = '0;
    sel     = 0;
    for (int m = 0; m < int'(NUM_MASTERS); m++) begin
      sel        = int'(i_master_addr[m][SEL_LSB +: SEL_W]);
      dec_err[m] = i_master_req[m] && (sel >= NUM_SLAVES);
      for (int s = 0; s < int'(NUM_SLAVES); s++)
        cand[s][m] = i_master_req[m] && !busy_q[m] && !rst && (sel == s);
    end
  end

  for (genvar s = 0; s < int'(NUM_SLAVES); s++) begin : g_arb
    xbar_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (cand[s]),
      .lock_hold_i (lock_hold[s]),
      .advance_i   (accept[s]),
      .gnt_o       (arb_gnt[s]),
      .winner_o    (arb_win[s])
    );
  end

  always_comb begin
    o_slave_req   = '0;
    o_slave_we    = '0;
    o_slave_addr  = '0;
    o_slave_wdata = '0;
    for (int s = 0; s < int'(NUM_SLAVES); s++) begin
      full[s]      = (cnt_q[s] == (PW+1)'(RSP_DEPTH));
      // A full FIFO hides the request; any existing lock stays in the arbiter.
      slv_req[s]   = (|arb_gnt[s]) && !full[s];
      accept[s]    = slv_req[s] && i_slave_gnt[s];
      lock_hold[s] = slv_req[s] && !i_slave_gnt[s];
      pop[s]       = i_slave_rvalid[s] && (cnt_q[s] != '0) && !rst;
      push_ent[s]  = '{we: i_master_we[arb_win[s]], id: MAX_ID_W'(arb_win[s])};
      if (slv_req[s]) begin
        o_slave_req[s]   = 1'b1;
        o_slave_we[s]    = i_master_we[arb_win[s]];
        o_slave_addr[s]  = i_master_addr[arb_win[s]];
        o_slave_wdata[s] = i_master_wdata[arb_win[s]];
      end
    end
  end

  always_comb begin
    o_master_gnt    = '0;
    o_master_rvalid = '0;
    o_master_rdata  = '0;
    o_master_err    = '0;
    dec_gnt         = '0;
    head            = '0;
    for (int m = 0; m < int'(NUM_MASTERS); m++) begin
      dec_gnt[m] = dec_err[m] && !busy_q[m] && !rst;
      if (errp_q[m] && !rst) begin
        o_master_rvalid[m] = 1'b1;
        o_master_err[m]    = 1'b1;
      end
    end
    o_master_gnt = dec_gnt;
    for (int s = 0; s < int'(NUM_SLAVES); s++) begin
      head = fifo_q[s][rd_ptr_q[s]];
      for (int m = 0; m < int'(NUM_MASTERS); m++) begin
        if (accept[s] && arb_gnt[s][m]) o_master_gnt[m] = 1'b1;
        if (pop[s] && head.id == MAX_ID_W'(m)) begin
          o_master_rvalid[m] = 1'b1;
          o_master_rdata[m]  = head.we ? '0 : i_slave_rdata[s];
        end
      end
    end
  end

  assign busy_d = (busy_q | o_master_gnt) & ~o_master_rvalid;

  always_ff @(posedge clk) begin
    recent_rst_q <= rst;
    if (rst) begin
      busy_q <= '0;
      errp_q <= '0;
      for (int s = 0; s < int'(NUM_SLAVES); s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      busy_q <= busy_d;
      errp_q <= dec_gnt;
      for (int s = 0; s < int'(NUM_SLAVES); s++) begin
        if (accept[s]) wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
        if (pop[s])    rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
        case ({accept[s], pop[s]})
          2'b10:   cnt_q[s] <= cnt_q[s] + 1'b1;
          2'b01:   cnt_q[s] <= cnt_q[s] - 1'b1;
          default: cnt_q[s] <= cnt_q[s];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < int'(NUM_SLAVES); s++)
      if (accept[s]) fifo_q[s][wr_ptr_q[s]] <= push_ent[s];
  end

`ifndef SYNTHESIS
  // Responses with nothing outstanding are only tolerated right after reset.
  always_ff @(posedge clk) begin
    if (!rst && !recent_rst_q)
      for (int s = 0; s < int'(NUM_SLAVES); s++)
        assert (!(i_slave_rvalid[s] && cnt_q[s] == '0));
  end
`endif

endmodule

// File: tb/tb_xbar_interconnect.sv
// Directed bench for xbar_interconnect (6 masters, 3 slaves, depth-4 ID FIFOs);
// master responses are checked against a queue of expected {master, err, data}.
module tb_xbar_interconnect;

  localparam int M  = 6;
  localparam int S  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 3 + 1 + DW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [M-1:0]           i_master_req, i_master_we;
  logic [M-1:0][AW-1:0]   i_master_addr;
  logic [M-1:0][DW-1:0]   i_master_wdata;
  logic [M-1:0]           o_master_gnt, o_master_rvalid, o_master_err;
  logic [M-1:0][DW-1:0]   o_master_rdata;
  logic [S-1:0]           o_slave_req, o_slave_we;
  logic [S-1:0][AW-1:0]   o_slave_addr;
  logic [S-1:0][DW-1:0]   o_slave_wdata;
  logic [S-1:0]           i_slave_gnt, i_slave_rvalid;
  logic [S-1:0][DW-1:0]   i_slave_rdata;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  xbar_interconnect #(
    .NUM_MASTERS(M), .NUM_SLAVES(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SEL_LSB(14), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_master_req(i_master_req), .i_master_we(i_master_we),
    .i_master_addr(i_master_addr), .i_master_wdata(i_master_wdata),
    .o_master_gnt(o_master_gnt), .o_master_rvalid(o_master_rvalid),
    .o_master_rdata(o_master_rdata), .o_master_err(o_master_err),
    .o_slave_req(o_slave_req), .o_slave_we(o_slave_we),
    .o_slave_addr(o_slave_addr), .o_slave_wdata(o_slave_wdata),
    .i_slave_gnt(i_slave_gnt), .i_slave_rvalid(i_slave_rvalid),
    .i_slave_rdata(i_slave_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    i_master_req   = '0;
    i_master_we    = '0;
    i_master_addr  = '0;
    i_master_wdata = '0;
    i_slave_gnt    = '0;
    i_slave_rvalid = '0;
    i_slave_rdata  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int m, input logic e, input logic [DW-1:0] d);
    return {3'(m), e, d};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int m = 0; m < M; m++) begin
        if (o_master_rvalid[m]) begin
          logic [EW-1:0] got, want;
          got  = {3'(m), o_master_err[m], o_master_rdata[m]};
          want = '1;
          if (exp_q.size() != 0) want = exp_q.pop_front();
          checks++;
          assert (got === want)
          else begin
            errors++;
            $error("FAIL rsp m%0d observed=%0h expected=%0h", m, got, want);
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [DW-1:0] d0, d1;
  logic [DW-1:0] fd [5];
  logic [M-1:0]  mask;

  initial begin
    rst = 1'b1;
    clear_inputs();
    step(); step();
    sample();
    chk("rst_mgnt", 64'(o_master_gnt), 0);
    chk("rst_sreq", 64'(o_slave_req), 0);
    chk("rst_rvalid", 64'(o_master_rvalid), 0);
    step(); rst = 1'b0;
    sample(); step();

    // single read, M0 -> slave1
    i_master_req[0] = 1'b1; i_master_addr[0] = 32'h0000_4010; i_slave_gnt[1] = 1'b1;
    sample();
    chk("t1_sreq", 64'(o_slave_req), 64'b010);
    chk("t1_saddr", 64'(o_slave_addr[1]), 64'h4010);
    chk("t1_swe", 64'(o_slave_we[1]), 0);
    chk("t1_mgnt", 64'(o_master_gnt), 64'b000001);
    exp_q.push_back(mk(0, 1'b0, 32'hDEAD_BEEF));
    step();
    sample();
    chk("t1_busy_sreq", 64'(o_slave_req), 0);
    chk("t1_busy_mgnt", 64'(o_master_gnt), 0);
    step(); clear_inputs();
    sample(); step();
    i_slave_rvalid[1] = 1'b1; i_slave_rdata[1] = 32'hDEAD_BEEF;
    sample();
    chk("t1_rvalid", 64'(o_master_rvalid), 64'b000001);
    step(); clear_inputs();

    // parallel: M0 read slave0, M1 write slave2
    d0 = $urandom;
    i_master_req[1:0] = 2'b11; i_master_addr[0] = 32'h0000_0000;
    i_master_addr[1] = 32'h0000_8000; i_master_we[1] = 1'b1; i_master_wdata[1] = 32'h1234_5678;
    i_slave_gnt = 3'b101;
    sample();
    chk("t2_sreq", 64'(o_slave_req), 64'b101);
    chk("t2_mgnt", 64'(o_master_gnt), 64'b000011);
    chk("t2_swe", 64'(o_slave_we[2]), 1);
    chk("t2_swdata", 64'(o_slave_wdata[2]), 64'h1234_5678);
    exp_q.push_back(mk(0, 1'b0, d0));
    exp_q.push_back(mk(1, 1'b0, 32'h0));
    step(); clear_inputs();
    i_slave_rvalid[0] = 1'b1; i_slave_rdata[0] = d0;
    sample(); step(); clear_inputs();
    i_slave_rvalid[2] = 1'b1; i_slave_rdata[2] = 32'hFFFF_FFFF;
    sample(); step(); clear_inputs();

    // contention on slave2: grants alternate M0, M1
    for (int r = 0; r < 4; r++) begin
      d1 = $urandom;
      i_master_req[1:0] = 2'b11;
      i_master_addr[0] = 32'h0000_8000; i_master_addr[1] = 32'h0000_8004;
      i_slave_gnt[2] = 1'b1;
      sample();
      chk($sformatf("t3_rr%0d", r), 64'(o_master_gnt), 64'(1 << (r % 2)));
      exp_q.push_back(mk(r % 2, 1'b0, d1));
      step(); clear_inputs();
      i_slave_rvalid[2] = 1'b1; i_slave_rdata[2] = d1;
      sample(); step(); clear_inputs();
    end

    // back-pressure lock: M1 locked on slave2 for 5 cycles while M0 waits
    i_master_req[1] = 1'b1; i_master_addr[1] = 32'h0000_8044;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        i_master_req[0] = 1'b1; i_master_addr[0] = 32'h0000_8088;
      end
      sample();
      chk($sformatf("t4_sreq%0d", c), 64'(o_slave_req[2]), 1);
      chk($sformatf("t4_saddr%0d", c), 64'(o_slave_addr[2]), 64'h8044);
      chk($sformatf("t4_mgnt%0d", c), 64'(o_master_gnt), 0);
      step();
    end
    d0 = $urandom_range(1, 32'hFFFF); d1 = $urandom_range(1, 32'hFFFF);
    i_slave_gnt[2] = 1'b1;
    sample();
    chk("t4_acc_m1", 64'(o_master_gnt), 64'b000010);
    exp_q.push_back(mk(1, 1'b0, d1));
    step();
    i_master_req[1] = 1'b0; i_slave_rvalid[2] = 1'b1; i_slave_rdata[2] = d1;
    sample();
    chk("t4_acc_m0", 64'(o_master_gnt), 64'b000001);
    chk("t4_saddr_m0", 64'(o_slave_addr[2]), 64'h8088);
    exp_q.push_back(mk(0, 1'b0, d0));
    step(); clear_inputs();
    i_slave_rvalid[2] = 1'b1; i_slave_rdata[2] = d0;
    sample(); step(); clear_inputs();

    // FIFO full on slave0: M1..M5 contend, ptr[0] is 1 after the M0 accept above
    for (int k = 0; k < 5; k++) fd[k] = $urandom;
    mask = 6'b111110;
    for (int m = 0; m < M; m++) i_master_addr[m] = 32'(m * 4);
    i_slave_gnt[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_master_req = mask;
      sample();
      chk($sformatf("t5_gnt%0d", k), 64'(o_master_gnt), 64'(1 << (k + 1)));
      exp_q.push_back(mk(k + 1, 1'b0, fd[k]));
      step();
      mask[k + 1] = 1'b0;
    end
    i_master_req = mask;
    sample();
    chk("t5_full_sreq", 64'(o_slave_req[0]), 0);
    chk("t5_full_mgnt", 64'(o_master_gnt), 0);
    step();
    i_slave_rvalid[0] = 1'b1; i_slave_rdata[0] = fd[0];
    sample();
    chk("t5_pop_mgnt", 64'(o_master_gnt), 0);
    step();
    i_slave_rvalid[0] = 1'b0;
    sample();
    chk("t5_after_pop", 64'(o_master_gnt), 64'b100000);
    exp_q.push_back(mk(5, 1'b0, fd[4]));
    step(); clear_inputs();
    for (int k = 1; k < 5; k++) begin
      i_slave_rvalid[0] = 1'b1; i_slave_rdata[0] = fd[k];
      sample(); step();
    end
    clear_inputs();

    // decode error: sel = 3 with three slaves
    i_master_req[2] = 1'b1; i_master_addr[2] = 32'h0000_C000;
    sample();
    chk("t6_dec_gnt", 64'(o_master_gnt), 64'b000100);
    chk("t6_dec_sreq", 64'(o_slave_req), 0);
    exp_q.push_back(mk(2, 1'b1, 32'h0));
    step(); clear_inputs();
    sample();
    chk("t6_dec_err", 64'(o_master_err), 64'b000100);
    step();

    // reset with M3 in flight on slave1
    i_master_req[3] = 1'b1; i_master_addr[3] = 32'h0000_4000; i_slave_gnt[1] = 1'b1;
    sample();
    chk("t6_m3_gnt", 64'(o_master_gnt), 64'b001000);
    step(); clear_inputs();
    rst = 1'b1;
    i_master_req[0] = 1'b1; i_slave_gnt[0] = 1'b1;
    sample();
    chk("t6_rst_mgnt", 64'(o_master_gnt), 0);
    chk("t6_rst_sreq", 64'(o_slave_req), 0);
    chk("t6_rst_rvalid", 64'(o_master_rvalid), 0);
    step(); clear_inputs();
    rst = 1'b0;
    i_slave_rvalid[1] = 1'b1; i_slave_rdata[1] = 32'hBAD0_BAD0;
    sample();
    chk("t6_late_rsp", 64'(o_master_rvalid), 0);
    step(); clear_inputs();

    // M3 is free again after reset
    d0 = $urandom;
    i_master_req[3] = 1'b1; i_master_addr[3] = 32'h0000_4000; i_slave_gnt[1] = 1'b1;
    sample();
    chk("t6_post_rst_gnt", 64'(o_master_gnt), 64'b001000);
    exp_q.push_back(mk(3, 1'b0, d0));
    step(); clear_inputs();
    i_slave_rvalid[1] = 1'b1; i_slave_rdata[1] = d0;
    sample(); step(); clear_inputs();
    sample();

    chk("exp_q_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
